// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the EX stage and the multi-cycle HI/LO engine.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, src_a, src_b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, src_a, src_b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine: fixed-latency multiply, 32-step restoring divide.
// Optional MULDIV_EARLY_OUT_EN finishes trivial divides (zero divisor, |a| < |b|) one cycle after accept.
module muldiv_sequencer #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic              clk,
    input  logic              resetn,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LAST = 6'd32;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic        pneg_q, pneg_d;
    logic        rneg_q, rneg_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        can_accept, accept;
    logic        sa, sb;
    logic [31:0] a_mag_in, b_mag_in;
    logic        early_out;
    logic [63:0] prod, prod_fix;
    logic [32:0] rem_sh, diff, rem_nx;
    logic        keep;
    logic [31:0] quo_nx, q_fix, r_fix;

    // Operand conditioning at accept: signed ops work on magnitudes.
    always_comb begin
        can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
        accept     = can_accept && bus.start && !bus.flush;
        sa         = ~bus.op[0] & bus.src_a[31];
        sb         = ~bus.op[0] & bus.src_b[31];
        a_mag_in   = sa ? -bus.src_a : bus.src_a;
        b_mag_in   = sb ? -bus.src_b : bus.src_b;
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = bus.op[1] && ((bus.src_b == 32'd0) || (a_mag_in < b_mag_in));
`else
    assign early_out = 1'b0;
`endif

    // One restoring step; rem_q[32] set means the shifted value already exceeds any divisor.
    always_comb begin
        prod     = {32'd0, a_mag_q} * {32'd0, b_mag_q};
        prod_fix = pneg_q ? -prod : prod;
        rem_sh   = {rem_q[31:0], quo_q[31]};
        keep     = rem_q[32] || (rem_sh >= {1'b0, b_mag_q});
        diff     = rem_sh - {1'b0, b_mag_q};
        rem_nx   = keep ? diff : rem_sh;
        quo_nx   = {quo_q[30:0], keep};
        q_fix    = pneg_q ? -quo_nx : quo_nx;
        r_fix    = rneg_q ? -rem_nx[31:0] : rem_nx[31:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start)            state_d = early_out ? S_DONE : (bus.op[1] ? S_DIV : S_MUL);
                    else if (state_q == S_DONE) state_d = S_IDLE;
                end
                S_MUL:   if (cnt_q == MUL_LAST) state_d = S_DONE;
                S_DIV:   if (cnt_q == DIV_LAST) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state_q == S_MUL) || (state_q == S_DIV);
        bus.done = (state_q == S_DONE);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        a_raw_d = a_raw_q;
        pneg_d  = pneg_q;
        rneg_d  = rneg_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (bus.flush) begin
            cnt_d = 6'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    cnt_d = 6'd0;
                    if (accept) begin
                        a_mag_d = a_mag_in;
                        b_mag_d = b_mag_in;
                        a_raw_d = bus.src_a;
                        pneg_d  = sa ^ sb;
                        rneg_d  = sa;
                        rem_d   = 33'd0;
                        quo_d   = a_mag_in;
                        cnt_d   = 6'd1;
                        // Trivial divide: remainder is the dividend itself in both sub-cases.
                        if (early_out) begin
                            hi_d = bus.src_a;
                            lo_d = (bus.src_b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                        end
                    end
                end
                S_MUL: begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == MUL_LAST) {hi_d, lo_d} = prod_fix;
                end
                S_DIV: begin
                    cnt_d = cnt_q + 6'd1;
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q == DIV_LAST) begin
                        if (b_mag_q == 32'd0) begin
                            hi_d = a_raw_q;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            hi_d = r_fix;
                            lo_d = q_fix;
                        end
                    end
                end
                default: cnt_d = 6'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= 6'd0;
            a_mag_q <= 32'd0;
            b_mag_q <= 32'd0;
            a_raw_q <= 32'd0;
            pneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= 33'd0;
            quo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            a_raw_q <= a_raw_d;
            pneg_q  <= pneg_d;
            rneg_q  <= rneg_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector table plus hand sequences for flush, back-to-back issue and async reset.
module tb_muldiv_sequencer;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.MUL_CYCLES(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          trivial;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge: the following posedge is cycle 0; returns at the cycle-1 negedge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        while (!bus.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int lat, cyc, exp_lat;
        logic [31:0] last_hi, last_lo;
        bit saw_done;

        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MULT,  32'hFFFFFFFE, 32'h00000003, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
        vecs[3]  = '{MULT,  32'h00000007, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[4]  = '{MULTU, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000};
        vecs[5]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{DIVU,  32'd100,      32'd7,        1'b0, 32'd2,        32'd14};
        vecs[7]  = '{DIVU,  32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 32'hFFFFFFFF};
        vecs[8]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
        vecs[9]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{DIV,   32'hFFFFFFFB, 32'h00000000, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[11] = '{DIVU,  32'd3,        32'd10,       1'b1, 32'd3,        32'd0};
        vecs[12] = '{DIV,   32'hFFFFFFFD, 32'd10,       1'b1, 32'hFFFFFFFD, 32'd0};
        vecs[13] = '{DIVU,  32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        32'hFFFFFFFF};
        vecs[14] = '{DIVU,  32'd7,        32'd7,        1'b0, 32'd0,        32'd1};
        vecs[15] = '{DIV,   32'h80000000, 32'd2,        1'b0, 32'd0,        32'hC0000000};

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            exp_lat = !vecs[i].op[1] ? 4 : ((vecs[i].trivial && EARLY) ? 1 : 33);
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_c1", i), 64'(bus.busy), 64'(exp_lat > 1));
            wait_done(1, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
            chk($sformatf("v%0d_hilo", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i), 64'({bus.done, bus.busy}), 64'd0);
        end
        last_hi = vecs[15].hi;
        last_lo = vecs[15].lo;

        // Flush at cycle 10 of a divide: idle at 11, no done, result registers untouched.
        launch(DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy_c11", 64'(bus.busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            if (bus.done) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(saw_done), 64'd0);
        chk("flush_hilo_kept", {bus.hi, bus.lo}, {last_hi, last_lo});

        // start together with flush in IDLE must not be accepted.
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = DIVU; bus.src_a = 32'd5; bus.src_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("start_flush_rejected", 64'({bus.busy, bus.done}), 64'd0);

        // start while busy is ignored: operands of the running divide survive.
        launch(DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = MULTU; bus.src_a = 32'd3; bus.src_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(6, lat);
        chk("busy_start_latency", 64'(lat), 64'd33);
        chk("busy_start_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
        @(negedge clk);

        // Back-to-back: new MULTU issued in the DONE cycle of a divide.
        launch(DIVU, 32'd100, 32'd7);
        wait_done(1, lat);
        chk("b2b_div_latency", 64'(lat), 64'd33);
        chk("b2b_div_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
        launch(MULTU, 32'd3, 32'd5);
        chk("b2b_mul_busy", 64'(bus.busy), 64'd1);
        wait_done(1, cyc);
        chk("b2b_mul_latency", 64'(cyc), 64'd4);
        chk("b2b_mul_hilo", {bus.hi, bus.lo}, {32'd0, 32'd15});
        @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        launch(DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_after_idle", 64'({bus.busy, bus.done}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
